// File: rtl/ad9826_responder.sv
// ad9826_responder
//   Responder end of the AD9826 3-wire serial register port (SLOAD/SCLK/SDATA).
//   It stands in for the ADC in loopback/bring-up builds. The link is
//   oversampled on clk. The block decodes 16-bit frames (R/W, A2..A0, 3
//   don't-care bits, D8..D0, MSB first), keeps eight 9-bit registers, and
//   drives read data back onto SDATA.
//
//   Build option: define AD9826_RESP_READ_EN to enable read-back. When it is
//   undefined, read frames are still clocked through to the end but commit
//   nothing, and the SDATA driver is tied off (sdata_oe=0, sdata_out=0).
//
// Ports
//   clk, rst         system clock (>= 8x SCLK), async active-high reset
//   sload            frame select, active-low
//   sclk             serial clock, low between frames
//   sdata_in         SDATA pad input
//   sdata_out/_oe    SDATA pad output / output enable
//   regs             register file, reg n at [9n+8:9n]
//   wr_stb           one-clk pulse on write commit
//   wr_addr/wr_data  last committed write
//   frame_err        one-clk pulse when a short frame is aborted
//   busy             synchronized sload is low
module ad9826_responder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sload,
  input  logic        sclk,
  input  logic        sdata_in,
  output logic        sdata_out,
  output logic        sdata_oe,
  output logic [71:0] regs,
  output logic        wr_stb,
  output logic [2:0]  wr_addr,
  output logic [8:0]  wr_data,
  output logic        frame_err,
  output logic        busy
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HDR  = 3'd1;
  localparam logic [2:0] S_RD   = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  // Synchronizers. sload resets high so that reset is not seen as a frame start.
  logic [SYNC_STAGES-1:0] sload_sy, sclk_sy, sdin_sy;
  logic                   sload_d, sclk_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sload_sy <= '1;
      sclk_sy  <= '0;
      sdin_sy  <= '0;
      sload_d  <= 1'b1;
      sclk_d   <= 1'b0;
    end else begin
      sload_sy <= {sload_sy[SYNC_STAGES-2:0], sload};
      sclk_sy  <= {sclk_sy[SYNC_STAGES-2:0], sclk};
      sdin_sy  <= {sdin_sy[SYNC_STAGES-2:0], sdata_in};
      sload_d  <= sload_sy[SYNC_STAGES-1];
      sclk_d   <= sclk_sy[SYNC_STAGES-1];
    end
  end

  logic sload_s, sclk_s, sdin_s;
  logic sload_fall, sload_rise, sclk_rise, sclk_fall;

  assign sload_s    = sload_sy[SYNC_STAGES-1];
  assign sclk_s     = sclk_sy[SYNC_STAGES-1];
  assign sdin_s     = sdin_sy[SYNC_STAGES-1];
  assign sload_fall = sload_d & ~sload_s;
  assign sload_rise = ~sload_d & sload_s;
  // sclk edges only count inside a frame.
  assign sclk_rise  = sclk_s & ~sclk_d & ~sload_s;
  assign sclk_fall  = ~sclk_s & sclk_d & ~sload_s;
  assign busy       = ~sload_s;

  logic [2:0]       state;
  logic [4:0]       bit_cnt;
  logic [8:0]       shreg;
  logic [8:0]       shift_nxt;
  logic             rw;
  logic [2:0]       addr;
  logic [7:0][8:0]  regs_q;

  assign shift_nxt = {shreg[7:0], sdin_s};
  assign regs      = regs_q;

  // A 9-bit shifter is enough: after the 7th rise it holds R/W at [6] and the
  // address at [5:3]; after the 16th it holds D8..D0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      rw        <= 1'b0;
      addr      <= '0;
      regs_q    <= '0;
      wr_stb    <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      frame_err <= 1'b0;
    end else begin
      wr_stb    <= 1'b0;
      frame_err <= 1'b0;

      if (sload_s)
        bit_cnt <= '0;
      else if (sclk_rise && bit_cnt != 5'd16)
        bit_cnt <= bit_cnt + 5'd1;

      case (state)
        S_IDLE: if (sload_fall) state <= S_HDR;
        S_HDR: begin
          if (sload_rise) begin
            frame_err <= 1'b1;
            state     <= S_IDLE;
          end else if (sclk_rise) begin
            shreg <= shift_nxt;
            if (bit_cnt == 5'd6) begin
              rw   <= shift_nxt[6];
              addr <= shift_nxt[5:3];
`ifdef AD9826_RESP_READ_EN
              state <= shift_nxt[6] ? S_RD : S_WR;
`else
              // Reads run through the write shifter and are dropped at DONE.
              state <= S_WR;
`endif
            end
          end
        end
        S_RD, S_WR: begin
          if (sload_rise) begin
            frame_err <= 1'b1;
            state     <= S_IDLE;
          end else if (sclk_rise) begin
            if (state == S_WR) shreg <= shift_nxt;
            if (bit_cnt == 5'd15) state <= S_DONE;
          end
        end
        S_DONE: begin
          // Extra sclk edges are ignored here; only sload matters.
          if (sload_rise) begin
            if (!rw) begin
              regs_q[addr] <= shreg;
              wr_stb       <= 1'b1;
              wr_addr      <= addr;
              wr_data      <= shreg;
            end
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef AD9826_RESP_READ_EN
  // Read-back driver. oe rises on the 7th rise of a read header, bits shift
  // out on the following falls, and oe drops on the fall after the 16th rise
  // (state DONE) or on any sload rise, whichever comes first.
  logic [8:0] rd_sh;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sdata_oe  <= 1'b0;
      sdata_out <= 1'b0;
      rd_sh     <= '0;
    end else if (state == S_HDR && sclk_rise && bit_cnt == 5'd6 && shift_nxt[6]) begin
      sdata_oe <= 1'b1;
      rd_sh    <= regs_q[shift_nxt[5:3]];
    end else if (sload_rise || (state == S_DONE && sclk_fall)) begin
      sdata_oe  <= 1'b0;
      sdata_out <= 1'b0;
    end else if (state == S_RD && sclk_fall) begin
      sdata_out <= rd_sh[8];
      rd_sh     <= {rd_sh[7:0], 1'b0};
    end
  end
`else
  assign sdata_oe  = 1'b0;
  assign sdata_out = 1'b0;
`endif

endmodule

// File: tb/tb_ad9826_responder.sv
module tb_ad9826_responder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sload = 1'b1;
  logic        sclk = 1'b0;
  logic        sdata_in = 1'b0;
  logic        sdata_out, sdata_oe, wr_stb, frame_err, busy;
  logic [71:0] regs;
  logic [2:0]  wr_addr;
  logic [8:0]  wr_data;

  ad9826_responder #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sload(sload), .sclk(sclk), .sdata_in(sdata_in),
    .sdata_out(sdata_out), .sdata_oe(sdata_oe), .regs(regs),
    .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int wr_cnt = 0;
  int err_cnt = 0;

  always @(posedge clk) begin
    if (wr_stb) wr_cnt <= wr_cnt + 1;
    if (frame_err) err_cnt <= err_cnt + 1;
  end

`ifdef AD9826_RESP_READ_EN
  localparam bit READ_EN = 1'b1;
`else
  localparam bit READ_EN = 1'b0;
`endif

  logic [7:0][8:0] model;
  logic [2:0]      exp_wa;
  logic [8:0]      exp_wd;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Master: SCLK half period = 8 clk. Data changes 4 clk after each fall; the
  // master samples SDATA/OE just before each rise.
  task automatic do_frame(input logic [15:0] w, input int rises,
                          output logic [8:0] rd, output logic [31:0] oem,
                          output logic oe_end);
    rd  = '0;
    oem = '0;
    sload = 1'b0;
    wait_clk(8);
    for (int i = 0; i < rises; i++) begin
      sdata_in = (i < 16) ? w[15-i] : 1'b1;
      wait_clk(4);
      oem[i] = sdata_oe;
      if (i >= 7 && i < 16) rd = {rd[7:0], sdata_out};
      sclk = 1'b1;
      wait_clk(8);
      sclk = 1'b0;
      wait_clk(4);
    end
    wait_clk(2);
    oe_end = sdata_oe;
    sload = 1'b1;
    sdata_in = 1'b0;
    wait_clk(8);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_regs"}, regs, 72'h0);
    chk({tag, "_ctl"}, {65'h0, sdata_out, sdata_oe, wr_stb, frame_err, busy},
        72'h0);
    chk({tag, "_wr"}, {60'h0, wr_addr, wr_data}, 72'h0);
  endtask

  typedef struct {
    logic [15:0] w;
    int          rises;
    logic        commit;
    logic        err;
    logic        is_rd;
    logic [8:0]  rd;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [8:0]  rd;
    logic [31:0] oem;
    logic        oe_end;
    int          w0, e0;

    vecs[0] = '{16'h20A5, 16, 1'b1, 1'b0, 1'b0, 9'h000}; // addr 2 <= 0x0A5
    vecs[1] = '{16'hA000, 16, 1'b0, 1'b0, 1'b1, 9'h0A5}; // read addr 2
    vecs[2] = '{16'h71FF, 16, 1'b1, 1'b0, 1'b0, 9'h000}; // addr 7 <= 0x1FF
    vecs[3] = '{16'h7000, 10, 1'b0, 1'b1, 1'b0, 9'h000}; // aborted after 10 bits
    vecs[4] = '{16'h4123, 20, 1'b1, 1'b0, 1'b0, 9'h000}; // 20 edges, addr 4 <= 0x123

    model  = '0;
    exp_wa = '0;
    exp_wd = '0;

    wait_clk(3);
    chk_idle_outputs("in_reset");
    rst = 1'b0;
    wait_clk(5);
    chk_idle_outputs("after_reset");

    for (int v = 0; v < 5; v++) begin
      w0 = wr_cnt;
      e0 = err_cnt;
      do_frame(vecs[v].w, vecs[v].rises, rd, oem, oe_end);
      if (vecs[v].commit) begin
        model[vecs[v].w[14:12]] = vecs[v].w[8:0];
        exp_wa = vecs[v].w[14:12];
        exp_wd = vecs[v].w[8:0];
      end
      chk($sformatf("v%0d_wr_stb_count", v), 72'(wr_cnt - w0), 72'(vecs[v].commit));
      chk($sformatf("v%0d_frame_err_count", v), 72'(err_cnt - e0), 72'(vecs[v].err));
      chk($sformatf("v%0d_wr_addr", v), 72'(wr_addr), 72'(exp_wa));
      chk($sformatf("v%0d_wr_data", v), 72'(wr_data), 72'(exp_wd));
      chk($sformatf("v%0d_regs", v), regs, model);
      chk($sformatf("v%0d_oe_per_bit", v), 72'(oem),
          (vecs[v].is_rd && READ_EN) ? 72'h0000_FF80 : 72'h0);
      chk($sformatf("v%0d_oe_after_last_fall", v), 72'(oe_end), 72'h0);
      if (vecs[v].is_rd && READ_EN)
        chk($sformatf("v%0d_read_data", v), 72'(rd), 72'(vecs[v].rd));
    end

    // Reset in the middle of a write: the pending write is dropped.
    w0 = wr_cnt;
    sload = 1'b0;
    wait_clk(8);
    for (int i = 0; i < 12; i++) begin
      logic [15:0] fw;
      fw = 16'h3055;
      sdata_in = fw[15-i];
      wait_clk(4);
      sclk = 1'b1;
      wait_clk(8);
      sclk = 1'b0;
      wait_clk(4);
    end
    chk("busy_mid_frame", 72'(busy), 72'h1);
    rst = 1'b1;
    sload = 1'b1;
    sdata_in = 1'b0;
    wait_clk(2);
    chk_idle_outputs("mid_frame_reset");
    rst = 1'b0;
    wait_clk(8);
    chk_idle_outputs("post_mid_reset");
    chk("reset_no_commit", 72'(wr_cnt - w0), 72'h0);
    model  = '0;

    w0 = wr_cnt;
    e0 = err_cnt;
    do_frame(16'h3055, 16, rd, oem, oe_end);
    model[3] = 9'h055;
    chk("rewrite_wr_stb_count", 72'(wr_cnt - w0), 72'h1);
    chk("rewrite_frame_err_count", 72'(err_cnt - e0), 72'h0);
    chk("rewrite_wr_addr", 72'(wr_addr), 72'h3);
    chk("rewrite_wr_data", 72'(wr_data), 72'h055);
    chk("rewrite_regs", regs, model);

    // Read of reg 3 (or a silent read in the write-only build).
    w0 = wr_cnt;
    do_frame(16'hB000, 16, rd, oem, oe_end);
    chk("read3_no_commit", 72'(wr_cnt - w0), 72'h0);
    chk("read3_regs", regs, model);
    chk("read3_oe", 72'(oem), READ_EN ? 72'h0000_FF80 : 72'h0);
    if (READ_EN) chk("read3_data", 72'(rd), 72'h055);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog: the run is bounded in time.
  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end
endmodule
